// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared types, constants and address helper for the memory arbiter
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL_I = 2'd1,
        FILL_D = 2'd2
    } arbState_t;

    localparam int          BLOCK_WORDS = 8;
    localparam logic [15:0] OFFSET_MASK = 16'hFFF0;
    localparam logic [15:0] WORD_STRIDE = 16'd2;

    // Byte address of word idx within a block; wraps modulo 2^16.
    function automatic logic [15:0] wordAddr(input logic [15:0] base, input logic [15:0] idx);
        return base + idx * WORD_STRIDE;
    endfunction

endpackage

// File: rtl/mem_arbiter_word_counter.sv
// rtl/mem_arbiter_word_counter.sv - block word counter with enable, clear and terminal flag
module word_counter #(
    parameter int WIDTH = 3,
    parameter int LAST  = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    output logic [WIDTH-1:0] count,
    output logic             terminal
);

    localparam logic [WIDTH-1:0] LAST_V = WIDTH'(LAST);

    assign terminal = (count == LAST_V);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= terminal ? '0 : count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - arbitrates I/D cache fills and D write-through onto one main-memory port
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int BLOCK_WORDS = mem_arbiter_pkg::BLOCK_WORDS,
    parameter int MEM_LATENCY = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        IReq,
    input  logic [15:0] IAddr,
    input  logic        DReq,
    input  logic [15:0] DAddr,
    input  logic        DWrReq,
    input  logic [15:0] DWrAddr,
    input  logic [15:0] DWrData,
    input  logic [15:0] MemDataIn,
    input  logic        MemDataValid,
    output logic        MemEnable,
    output logic        MemWr,
    output logic [15:0] MemAddr,
    output logic [15:0] MemDataOut,
    output logic [15:0] FillAddr,
    output logic [15:0] FillData,
    output logic        IFillWe,
    output logic        DFillWe,
    output logic        IStall,
    output logic        DStall
);

    localparam int CNT_W = $clog2(BLOCK_WORDS);

    // Memory latency only shapes the external memory; completion is counted on MemDataValid.
    if (MEM_LATENCY < 1) begin : gZeroLatency
    end

    arbState_t        state, nextState;
    logic [15:0]      base, baseNext;
    logic             issueDone;
    logic             inFill, issueEn, recvEn, lastWord, cntClr;
    logic [CNT_W-1:0] issueCnt, recvCnt;
    logic             issueTerm, recvTerm;

    assign inFill   = (state == FILL_I) || (state == FILL_D);
    assign issueEn  = inFill && !issueDone;
    assign recvEn   = inFill && MemDataValid;
    assign lastWord = recvEn && recvTerm;
    assign cntClr   = !inFill;

    word_counter #(.WIDTH(CNT_W), .LAST(BLOCK_WORDS - 1)) uIssueCnt (
        .clk      (clk),
        .rst      (rst),
        .en       (issueEn),
        .clr      (cntClr),
        .count    (issueCnt),
        .terminal (issueTerm)
    );

    word_counter #(.WIDTH(CNT_W), .LAST(BLOCK_WORDS - 1)) uRecvCnt (
        .clk      (clk),
        .rst      (rst),
        .en       (recvEn),
        .clr      (cntClr),
        .count    (recvCnt),
        .terminal (recvTerm)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            base      <= '0;
            issueDone <= 1'b0;
        end else begin
            state <= nextState;
            base  <= baseNext;
            if (lastWord || !inFill) begin
                issueDone <= 1'b0;
            end else if (issueEn && issueTerm) begin
                issueDone <= 1'b1;
            end
        end
    end

    always_comb begin
        nextState  = state;
        baseNext   = base;
        MemEnable  = 1'b0;
        MemWr      = 1'b0;
        MemAddr    = '0;
        MemDataOut = '0;
        FillAddr   = '0;
        FillData   = '0;
        IFillWe    = 1'b0;
        DFillWe    = 1'b0;

        case (state)
            IDLE: begin
                if (DWrReq) begin
                    MemEnable  = 1'b1;
                    MemWr      = 1'b1;
                    MemAddr    = DWrAddr;
                    MemDataOut = DWrData;
                end else if (DReq) begin
                    nextState = FILL_D;
                    baseNext  = DAddr & OFFSET_MASK;
                end else if (IReq) begin
                    nextState = FILL_I;
                    baseNext  = IAddr & OFFSET_MASK;
                end
            end
            FILL_I, FILL_D: begin
                if (issueEn) begin
                    MemEnable = 1'b1;
                    MemAddr   = wordAddr(base, 16'(issueCnt));
                end
                if (recvEn) begin
                    FillData = MemDataIn;
                    FillAddr = wordAddr(base, 16'(recvCnt));
                    IFillWe  = (state == FILL_I);
                    DFillWe  = (state == FILL_D);
                end
                // A pending I miss follows a D fill directly, without an IDLE bubble.
                if (lastWord) begin
                    if (state == FILL_D && IReq) begin
                        nextState = FILL_I;
                        baseNext  = IAddr & OFFSET_MASK;
                    end else begin
                        nextState = IDLE;
                    end
                end
            end
            default: nextState = IDLE;
        endcase

        IStall = IReq && !(state == FILL_I && lastWord);
        DStall = (DReq && !(state == FILL_D && lastWord)) || (DWrReq && state != IDLE);

        if (rst) begin
            MemEnable  = 1'b0;
            MemWr      = 1'b0;
            MemAddr    = '0;
            MemDataOut = '0;
            FillAddr   = '0;
            FillData   = '0;
            IFillWe    = 1'b0;
            DFillWe    = 1'b0;
            IStall     = 1'b0;
            DStall     = 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;

    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        IReq = 1'b0, DReq = 1'b0, DWrReq = 1'b0;
    logic [15:0] IAddr = '0, DAddr = '0, DWrAddr = '0, DWrData = '0;
    logic [15:0] MemDataIn;
    logic        MemDataValid;
    logic        MemEnable, MemWr, IFillWe, DFillWe, IStall, DStall;
    logic [15:0] MemAddr, MemDataOut, FillAddr, FillData;

    logic        forceValid = 1'b0;
    logic        pv [LAT] = '{default: 1'b0};
    logic [15:0] pa [LAT] = '{default: 16'h0};

    int checks   = 0;
    int failures = 0;

    mem_arbiter #(.BLOCK_WORDS(8), .MEM_LATENCY(LAT)) dut (
        .clk          (clk),
        .rst          (rst),
        .IReq         (IReq),
        .IAddr        (IAddr),
        .DReq         (DReq),
        .DAddr        (DAddr),
        .DWrReq       (DWrReq),
        .DWrAddr      (DWrAddr),
        .DWrData      (DWrData),
        .MemDataIn    (MemDataIn),
        .MemDataValid (MemDataValid),
        .MemEnable    (MemEnable),
        .MemWr        (MemWr),
        .MemAddr      (MemAddr),
        .MemDataOut   (MemDataOut),
        .FillAddr     (FillAddr),
        .FillData     (FillData),
        .IFillWe      (IFillWe),
        .DFillWe      (DFillWe),
        .IStall       (IStall),
        .DStall       (DStall)
    );

    always #5 clk = ~clk;

    // Fixed-latency memory: a read issued in cycle c returns addr^A5A5 in cycle c+LAT.
    always @(posedge clk) begin
        pv[0] <= MemEnable && !MemWr;
        pa[0] <= MemAddr;
        for (int k = 1; k < LAT; k++) begin
            pv[k] <= pv[k-1];
            pa[k] <= pa[k-1];
        end
    end
    assign MemDataValid = pv[LAT-1] || forceValid;
    assign MemDataIn    = pa[LAT-1] ^ 16'hA5A5;

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic checkIdleWrite(input logic [15:0] a, input logic [15:0] d);
        @(negedge clk);
        checkEq("wrMemEnable", MemEnable, 1);
        checkEq("wrMemWr", MemWr, 1);
        checkEq("wrMemAddr", MemAddr, a);
        checkEq("wrMemDataOut", MemDataOut, d);
        checkEq("wrDStall", DStall, 0);
    endtask

    // Checks fill cycles 0..11; caller holds the owning request high throughout.
    task automatic fillCheck(input bit isD, input logic [15:0] b, input bit expOther);
        logic [15:0] ia, ra;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            ia = b + 16'(2 * c);
            ra = b + 16'(2 * (c - 4));
            checkEq($sformatf("memEnable c%0d", c), MemEnable, c < 8);
            checkEq($sformatf("memWr c%0d", c), MemWr, 0);
            checkEq($sformatf("memAddr c%0d", c), MemAddr, (c < 8) ? ia : 16'h0);
            checkEq($sformatf("iFillWe c%0d", c), IFillWe, !isD && c >= 4);
            checkEq($sformatf("dFillWe c%0d", c), DFillWe, isD && c >= 4);
            checkEq($sformatf("fillAddr c%0d", c), FillAddr, (c >= 4) ? ra : 16'h0);
            checkEq($sformatf("fillData c%0d", c), FillData, (c >= 4) ? (ra ^ 16'hA5A5) : 16'h0);
            checkEq($sformatf("ownStall c%0d", c), isD ? DStall : IStall, c != 11);
            checkEq($sformatf("otherStall c%0d", c), isD ? IStall : DStall, expOther);
            if (c < 11) nextCycle();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        // Reset holds every command output low even with a write request present.
        #1;
        DWrReq = 1'b1; DWrAddr = 16'h1111; DWrData = 16'h2222;
        @(negedge clk);
        checkEq("rstMemEnable", MemEnable, 0);
        checkEq("rstMemWr", MemWr, 0);
        checkEq("rstMemAddr", MemAddr, 0);
        checkEq("rstMemDataOut", MemDataOut, 0);
        checkEq("rstFillWe", {IFillWe, DFillWe}, 0);
        nextCycle();
        DWrReq = 1'b0;
        rst = 1'b0;

        // Same-cycle write-through in IDLE.
        nextCycle();
        DWrReq = 1'b1; DWrAddr = 16'h8002; DWrData = 16'hBEEF;
        checkIdleWrite(16'h8002, 16'hBEEF);
        nextCycle();
        DWrReq = 1'b0;
        @(negedge clk);
        checkEq("wrDropMemEnable", MemEnable, 0);

        // Single I fill from 1236.
        nextCycle();
        IReq = 1'b1; IAddr = 16'h1236;
        @(negedge clk);
        checkEq("grantIStall", IStall, 1);
        checkEq("grantMemEnable", MemEnable, 0);
        nextCycle();
        fillCheck(1'b0, 16'h1230, 1'b0);
        nextCycle();
        IReq = 1'b0;
        DWrReq = 1'b1; DWrAddr = 16'h0010; DWrData = 16'h1234;
        checkIdleWrite(16'h0010, 16'h1234);
        nextCycle();
        DWrReq = 1'b0;

        // Simultaneous D and I misses: D first, then I with no bubble.
        nextCycle();
        IReq = 1'b1; IAddr = 16'h1236;
        DReq = 1'b1; DAddr = 16'h4000;
        @(negedge clk);
        checkEq("dualGrantDStall", DStall, 1);
        checkEq("dualGrantIStall", IStall, 1);
        nextCycle();
        fillCheck(1'b1, 16'h4000, 1'b1);
        nextCycle();
        DReq = 1'b0;
        fillCheck(1'b0, 16'h1230, 1'b0);
        nextCycle();
        IReq = 1'b0;

        // Write-through arriving during an I fill waits for IDLE.
        nextCycle();
        IReq = 1'b1; IAddr = 16'h2004;
        nextCycle();
        DWrReq = 1'b1; DWrAddr = 16'h3000; DWrData = 16'hCAFE;
        fillCheck(1'b0, 16'h2000, 1'b1);
        nextCycle();
        IReq = 1'b0;
        checkIdleWrite(16'h3000, 16'hCAFE);
        nextCycle();
        DWrReq = 1'b0;

        // Top-of-memory block does not wrap.
        nextCycle();
        IReq = 1'b1; IAddr = 16'hFFF8;
        nextCycle();
        fillCheck(1'b0, 16'hFFF0, 1'b0);
        nextCycle();
        IReq = 1'b0;

        // Reset mid-fill abandons it; later valids write nothing.
        nextCycle();
        IReq = 1'b1; IAddr = 16'h5000;
        nextCycle();
        for (int c = 0; c < 5; c++) nextCycle();
        rst = 1'b1;
        IReq = 1'b0;
        #1;
        checkEq("midRstMemEnable", MemEnable, 0);
        checkEq("midRstMemAddr", MemAddr, 0);
        checkEq("midRstFill", {FillAddr, FillData}, 0);
        checkEq("midRstFillWe", {IFillWe, DFillWe}, 0);
        checkEq("midRstStall", {IStall, DStall}, 0);
        nextCycle();
        rst = 1'b0;
        forceValid = 1'b1;
        for (int c = 6; c < 12; c++) begin
            @(negedge clk);
            checkEq($sformatf("staleFillWe c%0d", c), {IFillWe, DFillWe}, 0);
            checkEq($sformatf("staleFillAddr c%0d", c), FillAddr, 0);
            checkEq($sformatf("staleMemEnable c%0d", c), MemEnable, 0);
            nextCycle();
        end
        forceValid = 1'b0;
        DWrReq = 1'b1; DWrAddr = 16'h0042; DWrData = 16'h7777;
        checkIdleWrite(16'h0042, 16'h7777);
        nextCycle();
        DWrReq = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter BLOCK_WORDS, default 8: 16-bit words per cache block (16-byte block).
REQ-002 Parameter MEM_LATENCY, default 4: main-memory read latency in cycles, used only by the verification model.
REQ-003 Ports, clock and reset first: clk in 1, single clock, rising edge; rst in 1, asynchronous, active-high.
REQ-004 IReq in 1 I-cache miss; IAddr in 16 miss address.
REQ-005 DReq in 1 D-cache miss; DAddr in 16 miss address; DWrReq in 1 write-through request; DWrAddr in 16; DWrData in 16.
REQ-006 MemDataIn in 16 memory read data; MemDataValid in 1 read data valid.
REQ-007 MemEnable out 1; MemWr out 1; MemAddr out 16; MemDataOut out 16: main-memory command.
REQ-008 FillAddr out 16; FillData out 16: shared fill word; IFillWe out 1, DFillWe out 1: per-cache fill write enables.
REQ-009 IStall out 1, DStall out 1: stall to fetch stage and to the memory stage.

Function
REQ-010 States: IDLE, FILL_I, FILL_D; requests are sampled only in IDLE.
REQ-011 IDLE priority, highest first: DWrReq, DReq, IReq.
REQ-012 DWrReq in IDLE: same cycle MemEnable=1, MemWr=1, MemAddr=DWrAddr, MemDataOut=DWrData, DStall=0, state stays IDLE.
REQ-013 DWrReq outside IDLE: DStall=1 until serviced in IDLE.
REQ-014 DReq/IReq grant: base = Addr & 16'hFFF0, latched; next state FILL_D/FILL_I.
REQ-015 Fill issue: one read per cycle, MemEnable=1, MemWr=0, MemAddr = base + 2*issue_cnt, issue_cnt 0..BLOCK_WORDS-1, then MemEnable=0.
REQ-016 Fill receive: each MemDataValid in a FILL state drives FillData=MemDataIn, FillAddr = base + 2*recv_cnt, and the owning cache's FillWe=1; recv_cnt increments.
REQ-017 Completion is counted on MemDataValid, not timed; the cycle recv_cnt reaches BLOCK_WORDS-1 with valid is the last-word cycle.
REQ-018 After the last-word cycle: to FILL_I if IReq pending after a D fill, else IDLE; no bubble cycle.
REQ-019 IStall = IReq & ~(FILL_I last-word cycle); DStall = DReq & ~(FILL_D last-word cycle), OR REQ-013.
REQ-020 Request deassertion mid-fill is ignored; the fill completes.
REQ-021 MemDataValid in IDLE is ignored, with no FillWe.
REQ-022 Counters are 3 bits for the default and wrap to 0 on completion; address adds are 16-bit modulo.

Reset
REQ-023 rst forces state IDLE, both counters 0, latched base 0.
REQ-024 rst forces MemEnable, MemWr, IFillWe and DFillWe to 0 and MemAddr, MemDataOut, FillAddr and FillData to 0.
REQ-025 rst mid-fill abandons the fill; stale MemDataValid after reset is dropped per REQ-021.

Structure
REQ-026 Shared package holds: state enum, BLOCK_WORDS default, OFFSET_MASK 16'hFFF0, WORD_STRIDE 2.
REQ-027 Sub-module word_counter: 3-bit counter with enable, clear and terminal flag; instantiated twice, for issue and receive.

Verification
REQ-028 IReq with IAddr=16'h1236 -> MemAddr 16'h1230..16'h123E on cycles 0-7; IFillWe on cycles 4-11; IStall low cycle 11; IDLE cycle 12.
REQ-029 IReq and DReq same cycle, DAddr=16'h4000 -> D fill first; FILL_I entered cycle 12 with no bubble; IStall high throughout the D fill.
REQ-030 DWrReq in IDLE with 16'h8002/16'hBEEF -> same-cycle MemWr=1, MemAddr=16'h8002, MemDataOut=16'hBEEF, DStall=0.
REQ-031 DWrReq during an I fill -> DStall=1 until the fill ends; write issued on the first IDLE cycle.
REQ-032 rst asserted at fill cycle 5 -> all outputs 0 immediately; valids in cycles 6-11 produce no FillWe.
REQ-033 IReq with IAddr=16'hFFF8 -> addresses 16'hFFF0..16'hFFFE with no overflow into 16'h0000.
